// File: rtl/matvec_stream.sv
// Row-serial signed fixed-point J*x with LANES MACs per cycle; define MATVEC_SAT_EN to clip rows instead of wrapping.
// Latency: K=N/LANES cycles from accept to first row, then K+1 cycles per row with out_ready held high.
// Backpressure: a finished row is held until out_ready; no new matrix is accepted while busy.
module matvec_stream #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int LANES      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*N*DATA_WIDTH-1:0] J,
  input  logic [N*DATA_WIDTH-1:0]   x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_row,
  output logic [$clog2(N)-1:0]      out_idx,
  output logic                      out_last,
  output logic                      out_sat,
  output logic                      busy
);

  localparam int IDX_W     = $clog2(N);
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N);
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (FRAC_WIDTH-1);

  generate
    if ((N % LANES) != 0) begin : g_bad_lanes
      $error("matvec_stream: N must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  state_t                      state, state_d;
  logic [DATA_WIDTH-1:0]       j_m [N][N];
  logic [DATA_WIDTH-1:0]       x_m [N];
  logic [IDX_W-1:0]            row, col;
  logic signed [ACC_WIDTH-1:0] acc, acc_sum, rnd, shifted;
  logic                        last_col;
  logic [DATA_WIDTH-1:0]       row_res;
  logic                        row_sat;

  function automatic logic signed [2*DATA_WIDTH-1:0] smul(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
  endfunction

  assign last_col = (col == IDX_W'(N - LANES));

  always_comb begin
    acc_sum = acc;
    for (int l = 0; l < LANES; l++) begin
      acc_sum = acc_sum + ACC_WIDTH'(smul(j_m[row][col + IDX_W'(l)], x_m[col + IDX_W'(l)]));
    end
  end

  // Round half toward +inf before dropping the fractional bits of the product.
  assign rnd     = acc_sum + HALF;
  assign shifted = rnd >>> FRAC_WIDTH;

`ifdef MATVEC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    row_sat = 1'b1;
    row_res = MAX_V[DATA_WIDTH-1:0];
    if (shifted > MAX_V) begin
      row_res = MAX_V[DATA_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      row_res = MIN_V[DATA_WIDTH-1:0];
    end else begin
      row_sat = 1'b0;
      row_res = shifted[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_WIDTH-1:DATA_WIDTH];
  assign row_res   = shifted[DATA_WIDTH-1:0];
  assign row_sat   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = MAC;
      end
      MAC: begin
        if (last_col) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = out_last ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) j_m[r][c] <= '0;
        x_m[r] <= '0;
      end
      row      <= '0;
      col      <= '0;
      acc      <= '0;
      out_row  <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      out_sat  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) j_m[r][c] <= J[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
              x_m[r] <= x[r*DATA_WIDTH +: DATA_WIDTH];
            end
            row <= '0;
            col <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          col <= col + IDX_W'(LANES);
          if (last_col) begin
            out_row  <= row_res;
            out_idx  <= row;
            out_last <= (row == IDX_W'(N-1));
            out_sat  <= row_sat;
          end
        end
        EMIT: begin
          // Output registers stay frozen until the row is taken.
          if (out_ready && !out_last) begin
            row <= row + IDX_W'(1);
            col <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_stream.sv
// Bench for matvec_stream: directed and random matrices checked against a wide-integer reference model.
module tb_matvec_stream;
  localparam int N = 8, DW = 32, FW = 16, LANES = 2;

  logic            clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [N*N*DW-1:0] J = '0;
  logic [N*DW-1:0] x = '0;
  logic            in_ready, out_valid, out_last, out_sat, busy;
  logic [DW-1:0]   out_row;
  logic [2:0]      out_idx;

  matvec_stream #(.N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .J(J), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
    .out_last(out_last), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors = 0, miscompares = 0, acc_cyc = 0;
  logic [DW-1:0] jm [N][N];
  logic [DW-1:0] xv [N];
  logic [32:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) J[(r*N+c)*DW +: DW] = jm[r][c];
      x[r*DW +: DW] = xv[r];
    end
  endtask

  // Reference: exact wide dot product, round half up, then clip or wrap.
  function automatic void model_push();
    logic signed [127:0] sum, rv;
    for (int r = 0; r < N; r++) begin
      sum = '0;
      for (int c = 0; c < N; c++)
        sum = sum + 128'($signed(jm[r][c])) * 128'($signed(xv[c]));
      rv = (sum + (128'sd1 <<< (FW-1))) >>> FW;
`ifdef MATVEC_SAT_EN
      if (rv > 128'sd2147483647)       exp_q.push_back({1'b1, 32'h7FFF_FFFF});
      else if (rv < -128'sd2147483648) exp_q.push_back({1'b1, 32'h8000_0000});
      else                             exp_q.push_back({1'b0, rv[31:0]});
`else
      exp_q.push_back({1'b0, rv[31:0]});
`endif
    end
  endfunction

  task automatic fill(input logic [DW-1:0] jv, input logic [DW-1:0] xval);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) jm[r][c] = jv;
      xv[r] = xval;
    end
  endtask

  task automatic set_identity();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) jm[r][c] = (r == c) ? 32'h0001_0000 : 32'h0;
      xv[r] = 32'((r+1) << 16);
      exp_q.push_back({1'b0, 32'((r+1) << 16)});
    end
  endtask

  task automatic send(input bit hold);
    int n = 0;
    drive();
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_in_ready", in_ready, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    chk("accept_busy", busy, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_row, input bit rand_bp, output int first_lat);
    int            r = 0, waitc = 0;
    bit            stalled = 1'b0;
    logic [32:0]   e;
    logic [DW-1:0] hr;
    logic [2:0]    hi;
    first_lat = -1;
    while (r < N) begin
      if (!out_valid) begin
        if (waitc >= 100) begin
          chk("out_valid_timeout", out_valid, 1);
          return;
        end
        out_ready = 1'b1;
        @(posedge clk); #1; waitc++;
        continue;
      end
      if (first_lat < 0) first_lat = cyc - acc_cyc;
      if (r == stall_row && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        hr = out_row;
        hi = out_idx;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_row", out_row, hr);
          chk("stall_idx", out_idx, hi);
        end
        continue;
      end
      if (rand_bp && $urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("row", out_row, e[31:0]);
      chk("idx", out_idx, r);
      chk("last", out_last, (r == N-1));
      chk("sat", out_sat, e[32]);
      chk("in_ready_blocked", in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      r++;
      waitc = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: exact latency and full-matrix throughput.
    set_identity();
    send(1'b0);
    collect(-1, 1'b0, lat);
    chk("t1_latency", lat, 4);
    chk("t1_total_cycles", cyc - acc_cyc, 40);
    chk("t1_idle_in_ready", in_ready, 1);

    // Dense 2.0 x 0.5 over 8 columns.
    fill(32'h0002_0000, 32'h0000_8000);
    for (int r = 0; r < N; r++) exp_q.push_back({1'b0, 32'h0008_0000});
    send(1'b0);
    collect(-1, 1'b0, lat);

    // Rounding at exactly one half LSB, both signs.
    fill(32'h0, 32'h0);
    jm[0][0] = 32'h0000_0001;
    xv[0]    = 32'h0000_8000;
    exp_q.push_back({1'b0, 32'h0000_0001});
    for (int r = 1; r < N; r++) exp_q.push_back({1'b0, 32'h0});
    send(1'b0);
    collect(-1, 1'b0, lat);
    jm[0][0] = 32'hFFFF_FFFF;
    for (int r = 0; r < N; r++) exp_q.push_back({1'b0, 32'h0});
    send(1'b0);
    collect(-1, 1'b0, lat);

    // Overflow in both directions.
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    model_push();
    send(1'b0);
    collect(-1, 1'b0, lat);
    fill(32'h8000_0000, 32'h7FFF_FFFF);
    model_push();
    send(1'b0);
    collect(-1, 1'b0, lat);

    // Backpressure at row 3 while a second matrix is offered continuously.
    set_identity();
    send(1'b1);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) jm[r][c] = 32'(($urandom_range(0, 8) - 4) * 32768);
      xv[r] = 32'(($urandom_range(0, 8) - 4) * 65536);
    end
    drive();
    model_push();
    collect(3, 1'b0, lat);
    chk("t5_in_ready_after_last", in_ready, 1);
    chk("t5_busy_after_last", busy, 0);
    @(posedge clk); #1;
    chk("t5_second_accepted", busy, 1);
    chk("t5_second_in_ready", in_ready, 0);
    acc_cyc = cyc;
    in_valid = 1'b0;
    collect(-1, 1'b0, lat);
    chk("t5_second_latency", lat, 4);

    // Asynchronous reset during the row-2 MAC phase.
    set_identity();
    send(1'b0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_out_valid", out_valid, 0);
    chk("t6_pre_out_idx", out_idx, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_out_idx", out_idx, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_identity();
    send(1'b0);
    collect(-1, 1'b0, lat);
    chk("t6_fresh_latency", lat, 4);

    // Random matrices: full-range words, then small fixed-point values, with random backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++)
          jm[r][c] = (t < 3) ? $urandom : 32'(($urandom_range(0, 16) - 8) * 16384);
        xv[r] = (t < 3) ? $urandom : 32'(($urandom_range(0, 16) - 8) * 16384);
      end
      model_push();
      send(1'b0);
      collect(-1, 1'b1, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matvec_stream.md
# matvec_stream

Row-serial, parametrised successor to the combinational-tree matrix-vector multiplier, computing result = J·x in signed Qm.FRAC_WIDTH fixed point. It uses LANES parallel multiply-accumulate units, so area scales with LANES rather than N². It accepts a whole matrix/vector pair through a valid/ready handshake and streams one result row per output handshake, with round-to-nearest and optional saturation. It sits between the coupling-matrix store and the state-update stage.

## Interface
- N, default 8: matrix dimension.
- DATA_WIDTH, default 32: signed fixed-point word width.
- FRAC_WIDTH, default 16: fractional bits of J, x and result.
- LANES, default 2: MAC lanes (columns consumed per cycle). N % LANES must be 0; otherwise elaboration fails.
- Derived: K = N/LANES. ACC_WIDTH = 2*DATA_WIDTH + $clog2(N).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  J/x pair offered.
- in_ready  out  1  block idle and able to accept.
- J  in  N*N*DATA_WIDTH  matrix, packed [row][col], signed.
- x  in  N*DATA_WIDTH  vector, packed [col], signed.
- out_valid  out  1  out_row holds a finished row.
- out_ready  in  1  downstream accepts the row.
- out_row  out  DATA_WIDTH  result[out_idx], signed.
- out_idx  out  $clog2(N)  row index of out_row.
- out_last  out  1  out_idx == N-1.
- out_sat  out  1  out_row was clipped.
- busy  out  1  state != IDLE.

## Operation
- Three states: IDLE, MAC and EMIT.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: register J and x, set row=0, col=0, clear acc, go to MAC.
  - J and x are sampled only at this handshake. Later input changes have no effect on the result.
- **MAC**
  - Each cycle, add the LANES signed products J[row][col+l]·x[col+l], l=0..LANES-1, into the signed ACC_WIDTH acc. Then col += LANES.
  - After the cycle with col = N-LANES, compute the row result:
    - Take acc + 2^(FRAC_WIDTH-1).
    - Arithmetic shift right by FRAC_WIDTH (round half toward +inf).
    - Reduce to DATA_WIDTH (see Configuration).
  - Register the result into out_row/out_idx/out_last/out_sat and go to EMIT.
- **EMIT**
  - out_valid = 1. out_row, out_idx, out_last and out_sat are held stable until out_valid && out_ready.
  - On that handshake:
    - If out_last: go to IDLE.
    - Otherwise: row += 1, col = 0, clear acc, go to MAC.
- in_valid while busy is ignored (in_ready = 0). No input queueing.
- out_ready while out_valid = 0 has no effect.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_row 0, out_idx 0, out_last 0, out_sat 0, busy 0, acc 0, and J/x registers 0.
- Reset asserted mid-operation: aborts immediately (asynchronous). The partial matrix is discarded and no further outputs are produced for it.

## Timing
- The accept edge is edge 0. The MAC edges are 1..K, and out_valid rises after edge K. Latency from accept to first out_valid is K cycles.
- Each row after an output handshake takes K further cycles.
- Minimum cost per row is K+1 cycles, giving N·(K+1) cycles per matrix with out_ready held at 1.
- in_ready rises on the cycle after the last-row handshake. The earliest next accept is that cycle.
- LANES = N gives K = 1: one MAC cycle per row.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from out_ready or in_valid to any output.

## Configuration
- MATVEC_SAT_EN defined:
  - A rounded value outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] clips to the nearest bound and sets out_sat = 1 for that row.
  - Otherwise out_sat = 0.
- MATVEC_SAT_EN undefined:
  - out_row is the low DATA_WIDTH bits of the rounded value (two's-complement wrap).
  - out_sat is tied to 0.

## Test plan
All scenarios use N=8, DATA_WIDTH=32, FRAC_WIDTH=16, LANES=2 (K=4).
1. Identity: J diagonal 0x00010000, x[i] = (i+1)<<16.
   - Expect rows 0x00010000..0x00080000, out_idx 0..7, and out_last only on idx 7.
   - First out_valid exactly 4 cycles after accept; 40 cycles total with out_ready = 1.
2. Dense: all J = 0x00020000 (2.0), all x = 0x00008000 (0.5).
   - Every row = 0x00080000, out_sat = 0.
3. Rounding:
   - J[0][0] = 0x00000001, x[0] = 0x00008000, all else 0: row 0 = 0x00000001.
   - J[0][0] = 0xFFFFFFFF, same x: row 0 = 0x00000000.
4. Saturation: all J = x = 0x7FFFFFFF.
   - With MATVEC_SAT_EN: every row = 0x7FFFFFFF, out_sat = 1.
   - J = 0x80000000, x = 0x7FFFFFFF: every row = 0x80000000, out_sat = 1.
   - Without MATVEC_SAT_EN: rows equal the wrapped reference model value, out_sat = 0.
5. Backpressure and input blocking:
   - Hold out_ready = 0 for 5 cycles at row 3: out_row/out_idx stay stable, there is no progress, and no row is lost or duplicated.
   - Hold in_valid = 1 with new data throughout: the second matrix is accepted only on the cycle after the row-7 handshake.
   - The first matrix's results are unaffected by the new data.
6. Reset mid-operation:
   - Assert rst during row 2 MAC: out_valid and busy drop to 0 without waiting for a clock edge, and in_ready = 1.
   - After release, a fresh identity matrix produces correct rows 0..7.
